regfile_multiport: RTL and testbench

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

---
 rtl/regfile_multiport.sv | 63 ++++++
 tb/tb_regfile_multiport.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// regfile_multiport: 2-write / NUM_RD-read register file that self-clears after reset; x0 is hardwired to zero.
// Ports: clk, rst (sync, active-high); reg_write0/1, write_addr0/1, write_data0/1 (port 1 wins on a collision);
// read_addr / read_data packed per read port (slice k = port k, combinational); ready is high once the clear is done.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reg_write0,
  input  logic [ADDR_WIDTH-1:0]        write_addr0,
  input  logic [DATA_WIDTH-1:0]        write_data0,
  input  logic                         reg_write1,
  input  logic [ADDR_WIDTH-1:0]        write_addr1,
  input  logic [DATA_WIDTH-1:0]        write_data1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] read_data,
  output logic                         ready
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic we0, we1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : clr_cnt;
    end
  end
  always_comb state_nxt = (state == CLEAR && &clr_cnt) ? RUN : state;
  assign ready = state == RUN;
  // writes to x0 are dropped here so x0 can never hold anything but zero
  assign we0 = ready && reg_write0 && |write_addr0;
  assign we1 = ready && reg_write1 && |write_addr1;
  // port 1 assigned last so it wins an address collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_cnt] <= '0;
      else begin
        if (we0) mem[write_addr0] <= write_data0;
        if (we1) mem[write_addr1] <= write_data1;
      end
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    assign a = read_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
    assign d = (we1 && write_addr1 == a) ? write_data1 : (we0 && write_addr0 == a) ? write_data0 : mem[a];
`else
    assign d = mem[a];
`endif
    assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = (ready && |a) ? d : '0;
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed self-checking bench for regfile_multiport (32x32, two read ports).
module tb_regfile_multiport;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic reg_write0 = 0, reg_write1 = 0;
  logic [4:0] write_addr0 = 0, write_addr1 = 0;
  logic [31:0] write_data0 = 0, write_data1 = 0;
  logic [9:0] read_addr = 0;
  logic [63:0] read_data;
  logic ready;
  int total = 0, bad = 0;
  regfile_multiport dut (
    .clk(clk), .rst(rst),
    .reg_write0(reg_write0), .write_addr0(write_addr0), .write_data0(write_data0),
    .reg_write1(reg_write1), .write_addr1(write_addr1), .write_data1(write_data1),
    .read_addr(read_addr), .read_data(read_data), .ready(ready)
  );
  always #5 clk = ~clk;
  task automatic test_reset;
    int cnt = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    read_addr = {5'd3, 5'd4};
    reg_write0 = 1; write_addr0 = 5'd4; write_data0 = 32'h1234_5678;
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++;
    if (read_data !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
    while (ready !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    reg_write0 = 0;
    total++;
    if (cnt !== 32) begin bad++; $display("FAIL reset_clear_len got=%0d exp=32", cnt); end
    for (int i = 0; i < 32; i++) begin
      read_addr = {5'(31 - i), 5'(i)};
      #1;
      total++;
      if (read_data !== 64'h0) begin bad++; $display("FAIL reset_entry_%0d got=%h exp=0", i, read_data); end
    end
  endtask
  task automatic wr(input bit e0, input logic [4:0] a0, input logic [31:0] d0,
                    input bit e1, input logic [4:0] a1, input logic [31:0] d1);
    reg_write0 = e0; write_addr0 = a0; write_data0 = d0;
    reg_write1 = e1; write_addr1 = a1; write_data1 = d1;
    @(posedge clk); #1;
    reg_write0 = 0; reg_write1 = 0;
  endtask
  task automatic test_basic;
    wr(1, 5'd5, 32'hDEAD_BEEF, 1, 5'd31, 32'hCAFE_F00D);
    read_addr = {5'd5, 5'd5};
    #1;
    total++;
    if (read_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin bad++; $display("FAIL basic_x5 got=%h exp=%h", read_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF}); end
    read_addr = {5'd31, 5'd5};
    #1;
    total++;
    if (read_data !== {32'hCAFE_F00D, 32'hDEAD_BEEF}) begin bad++; $display("FAIL basic_split got=%h exp=%h", read_data, {32'hCAFE_F00D, 32'hDEAD_BEEF}); end
    read_addr = {5'd6, 5'd31};
    #1;
    total++;
    if (read_data !== {32'h0, 32'hCAFE_F00D}) begin bad++; $display("FAIL basic_x31 got=%h exp=%h", read_data, {32'h0, 32'hCAFE_F00D}); end
  endtask
  task automatic test_same_addr;
    wr(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
    read_addr = {5'd7, 5'd7};
    #1;
    total++;
    if (read_data !== {32'h22, 32'h22}) begin bad++; $display("FAIL same_addr got=%h exp=%h", read_data, {32'h22, 32'h22}); end
  endtask
  task automatic test_x0;
    read_addr = {5'd0, 5'd0};
    reg_write0 = 1; write_addr0 = 0; write_data0 = 32'hFFFF_FFFF;
    reg_write1 = 1; write_addr1 = 0; write_data1 = 32'hFFFF_FFFF;
    #1;
    total++;
    if (read_data !== 64'h0) begin bad++; $display("FAIL x0_same_cycle got=%h exp=0", read_data); end
    @(posedge clk); #1;
    reg_write0 = 0; reg_write1 = 0;
    total++;
    if (read_data !== 64'h0) begin bad++; $display("FAIL x0_after got=%h exp=0", read_data); end
  endtask
  task automatic test_bypass;
    logic [31:0] exp;
    wr(1, 5'd9, 32'h1111, 0, 0, 0);
    read_addr = {5'd9, 5'd9};
    reg_write0 = 1; write_addr0 = 5'd9; write_data0 = 32'hA5A5_A5A5;
    #1;
    exp = BYP ? 32'hA5A5_A5A5 : 32'h1111;
    total++;
    if (read_data !== {exp, exp}) begin bad++; $display("FAIL bypass_p0 got=%h exp=%h", read_data, {exp, exp}); end
    reg_write1 = 1; write_addr1 = 5'd9; write_data1 = 32'h5A5A_0001;
    #1;
    exp = BYP ? 32'h5A5A_0001 : 32'h1111;
    total++;
    if (read_data !== {exp, exp}) begin bad++; $display("FAIL bypass_p1_wins got=%h exp=%h", read_data, {exp, exp}); end
    @(posedge clk); #1;
    reg_write0 = 0; reg_write1 = 0;
    total++;
    if (read_data !== {32'h5A5A_0001, 32'h5A5A_0001}) begin bad++; $display("FAIL bypass_after got=%h exp=%h", read_data, {32'h5A5A_0001, 32'h5A5A_0001}); end
  endtask
  task automatic test_reset_mid_clear;
    int cnt = 0;
    wr(1, 5'd3, 32'h55, 0, 0, 0);
    read_addr = {5'd3, 5'd3};
    #1;
    total++;
    if (read_data !== {32'h55, 32'h55}) begin bad++; $display("FAIL mid_pre got=%h exp=%h", read_data, {32'h55, 32'h55}); end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0 || read_data !== 64'h0) begin bad++; $display("FAIL mid_clearing got=%b/%h exp=0/0", ready, read_data); end
    rst = 1;
    reg_write0 = 1; write_addr0 = 5'd3; write_data0 = 32'h77;
    @(posedge clk); #1;
    rst = 0; reg_write0 = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    total++;
    if (cnt !== 32) begin bad++; $display("FAIL mid_clear_len got=%0d exp=32", cnt); end
    total++;
    if (read_data !== 64'h0) begin bad++; $display("FAIL mid_x3 got=%h exp=0", read_data); end
    read_addr = {5'd5, 5'd7};
    #1;
    total++;
    if (read_data !== 64'h0) begin bad++; $display("FAIL mid_x5x7 got=%h exp=0", read_data); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_same_addr;
    test_x0;
    test_bypass;
    test_reset_mid_clear;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
